// File: rtl/instruction_fetch_unit_pkg.sv
// Shared widths, prefetch entry type and default reset PC for the instruction fetch unit.
package instruction_fetch_unit_pkg;

    localparam int FETCH_ADDR_W = 16;
    localparam int INSTR_W      = 32;

    localparam logic [FETCH_ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [INSTR_W-1:0]      data;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Prefetch FIFO of fetch entries with flush; head is read straight from registered storage.
module fetch_queue
    import instruction_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head,
    output logic                   head_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head outputs read as zero until the first push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign count      = count_q;
    assign head       = mem_q[rd_ptr_q];
    assign head_valid = (count_q != '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch initiator: pc/credit tracking, 1-cycle memory response capture, prefetch queue.
// Optional performance counters are enabled with `define FETCH_PERF_COUNTERS_EN.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                      DEPTH    = 4,
    parameter logic [FETCH_ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [FETCH_ADDR_W-1:0] fetchAddress,
    output logic                    fetchEnable,
    input  logic [INSTR_W-1:0]      fetchOutput,
    input  logic                    redirectValid,
    input  logic [FETCH_ADDR_W-1:0] redirectAddress,
    output logic                    instrValid,
    input  logic                    instrReady,
    output logic [INSTR_W-1:0]      instrData,
    output logic [FETCH_ADDR_W-1:0] instrPc
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]             perfFetchCount,
    output logic [31:0]             perfStallCount,
    output logic [15:0]             perfFlushCount
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    typedef logic [CNT_W:0] credit_t;

    logic [FETCH_ADDR_W-1:0] pc_q, pc_d;
    logic [FETCH_ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic                    inflight_q, inflight_d;
    logic [CNT_W-1:0]        count;
    credit_t                 credit_used;
    fetch_entry_t            head;
    fetch_entry_t            push_entry;
    logic                    head_valid;
    logic                    pop, push, issue;

    assign pop         = head_valid & instrReady;
    assign credit_used = credit_t'(count) + credit_t'(inflight_q);
    // A pop this cycle frees a slot, so it counts as credit; rst_n keeps the port quiet during reset.
    assign issue       = rst_n & !redirectValid
                       & (credit_used < credit_t'(DEPTH) + credit_t'(pop));
    assign push        = inflight_q & !redirectValid;
    assign push_entry  = '{pc: inflight_pc_q, data: fetchOutput};

    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        if (redirectValid) begin
            pc_d = redirectAddress;
        end else if (issue) begin
            pc_d          = pc_q + 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirectValid),
        .count      (count),
        .head       (head),
        .head_valid (head_valid)
    );

    assign fetchAddress = pc_q;
    assign fetchEnable  = issue;
    assign instrValid   = head_valid;
    assign instrData    = head.data;
    assign instrPc      = head.pc;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (issue)                    perf_fetch_d = perf_fetch_q + 32'd1;
        if (head_valid && !instrReady) perf_stall_d = perf_stall_q + 32'd1;
        if (redirectValid)            perf_flush_d = perf_flush_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perfFetchCount = perf_fetch_q;
    assign perfStallCount = perf_stall_q;
    assign perfFlushCount = perf_flush_q;
`endif

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-fetch port of the operational memory.
- Drives `fetchAddress`/`fetchEnable` and captures `fetchOutput` one cycle after each issue.
- Buffers fetched words with their PC in a small prefetch queue and hands them to decode with a valid/ready handshake.
- Handles control-flow redirects by flushing the queue and discarding any in-flight response.

Parameters:
- `DEPTH`, 4, prefetch queue entries (min 2; power of two).
- `RESET_PC`, 16'h0000, first fetch address after reset.

Ports:
- `clk`  input  1  system clock
- `rst_n`  input  1  asynchronous active-low reset
- `fetchAddress`  output  16  word address to memory fetch port
- `fetchEnable`  output  1  fetch request (memory read enable)
- `fetchOutput`  input  32  memory read data, valid the cycle after `fetchEnable`
- `redirectValid`  input  1  redirect request from execute/branch logic
- `redirectAddress`  input  16  new PC for the redirect
- `instrValid`  output  1  queue head valid
- `instrReady`  input  1  decode accepts head
- `instrData`  output  32  queue head instruction word
- `instrPc`  output  16  queue head PC

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - pc register = `RESET_PC`.
  - Queue empty; inflight = 0.
  - `instrValid` = 0, `fetchEnable` = 0.
  - `instrData` = 0, `instrPc` = 0.
  - First issue occurs in the first cycle after `rst_n` deasserts.
- `fetchAddress` = pc register (registered).
- pop = `instrValid` & `instrReady`.
- issue = !`redirectValid` & (count + inflight − pop < `DEPTH`); `fetchEnable` = issue.
- On issue:
  - pc <= pc + 1, modulo 2^16, so 16'hFFFF wraps to 16'h0000.
  - inflight <= 1; inflightPc <= pc.
  - With no issue, inflight <= 0.
- Memory latency is exactly 1 cycle. In the cycle after an issue, when inflight = 1 and no redirect, push {inflightPc, `fetchOutput`} into the queue.
- The credit rule guarantees no push into a full queue.
- Simultaneous push and pop in one cycle is legal at any occupancy; count stays the same.
- Sustained throughput is 1 instruction/cycle for `DEPTH` ≥ 2 with `instrReady` held high.
- Pipeline:
  - First instruction after reset or redirect appears on `instrValid` 2 cycles after the issue cycle: issue, response/push, head valid.
  - `instrValid`, `instrData` and `instrPc` come from queue registers only.
- Redirect, when `redirectValid` = 1 in cycle N:
  - pc <= `redirectAddress`; count <= 0; inflight <= 0.
  - Any response arriving in cycle N is discarded.
  - `fetchEnable` = 0 in cycle N; first fetch of `redirectAddress` in cycle N+1.
  - `instrValid` = 0 in cycle N+1.
- Redirect concurrent with pop: the handshake completes from decode's point of view; the flush dominates the queue state.
- Back-to-back redirects: the last one wins. No fetch is issued while `redirectValid` is held.
- `instrReady` low: head and all queue outputs hold stable. Issue stops once count + inflight = `DEPTH`.
- Asynchronous reset mid-operation: immediate return to reset state. The pending response is dropped because inflight is cleared.

Optional Feature:
- Macro: `FETCH_PERF_COUNTERS_EN`.
- With the macro defined, add three output ports:
  - `perfFetchCount` (32): counts issue cycles.
  - `perfStallCount` (32): counts cycles with `instrValid` & !`instrReady`.
  - `perfFlushCount` (16): counts redirect cycles.
- All three counters wrap on overflow and reset to 0.
- Without the macro, the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Shared package:
  - constants `FETCH_ADDR_W` = 16 and `INSTR_W` = 32.
  - typedef `fetch_entry_t` {pc[15:0], data[31:0]}.
  - `RESET_PC` default constant.
- Sub-module `fetch_queue`: synchronous FIFO of `fetch_entry_t`, `DEPTH` entries. Provides push, pop, flush, count, head; pointers wrap.
- The fetch unit holds the pc, inflight tracking and credit logic.

Test Plan:
- Reset, `instrReady` = 1, memory model returns addr ^ 32'hA5A5_0000 → `fetchEnable` high from cycle 1. `instrPc` sequence 0,1,2,3… one per cycle from cycle 3, with matching data.
- `instrReady` held 0 for 10 cycles, `DEPTH` = 4 → exactly 4 issues. `fetchEnable` then stays 0, head stays at PC 0. On release, PCs 0..3 drain with no gap or duplicate.
- `redirectValid` with `redirectAddress` = 16'h0100 while the queue holds PCs 5..7 and one fetch is in flight → the next `instrValid` shows PC 16'h0100. No stale PC appears; `fetchAddress` = 16'h0100 in cycle N+1.
- Redirect to 16'hFFFE → PCs FFFE, FFFF, 0000, 0001 delivered in order (wrap check).
- Random `instrReady` (50%) with redirects every 7–13 cycles for 5k cycles → scoreboard shows in-order PCs per epoch. No queue overflow; `fetchEnable` is never high in a redirect cycle.
- With `FETCH_PERF_COUNTERS_EN`: 20 cycles of steady fetch, 5 stall cycles, 2 redirects → `perfFlushCount` = 2 and `perfStallCount` = 5; `perfFetchCount` equals the observed `fetchEnable`-high cycles.
